// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - FIFO between fetch and decode with flush and NOP bubble on empty
module if_id_fetch_queue #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000000
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       push_valid,
    input  logic [INST_W-1:0]          push_inst,
    input  logic [PC_W-1:0]            push_pc,
    output logic                       push_ready,
    input  logic                       pop_ready,
    output logic                       pop_valid,
    output logic [INST_W-1:0]          pop_inst,
    output logic [PC_W-1:0]            pop_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W+INST_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push_fire;
    logic                   pop_fire;

    // Ready/valid depend on registered occupancy only; flush blocks both transfers.
    always_comb begin
        push_ready = (count != FULL_CNT);
        pop_valid  = (count != '0);
        push_fire  = push_valid & push_ready & ~flush;
        pop_fire   = pop_ready & pop_valid & ~flush;
    end

    // Head is read straight from storage; an empty queue presents a NOP bubble to decode.
    always_comb begin
        pop_inst = NOP_INST;
        pop_pc   = '0;
        if (pop_valid) begin
            pop_inst = mem[rd_ptr][INST_W-1:0];
            pop_pc   = mem[rd_ptr][PC_W+INST_W-1:INST_W];
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge Clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= {push_pc, push_inst};
        end
    end

    // Pointer and occupancy update; flush and reset empty the queue.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - randomized and directed bench for if_id_fetch_queue against a queue model
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_inst = '0;
    logic [31:0] push_pc = '0;
    logic        push_ready;
    logic        pop_ready = 1'b0;
    logic        pop_valid;
    logic [31:0] pop_inst;
    logic [31:0] pop_pc;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [63:0] model_q[$];

    if_id_fetch_queue #(
        .INST_W(32), .PC_W(32), .DEPTH(DEPTH), .NOP_INST(32'h00000000)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .push_valid(push_valid), .push_inst(push_inst), .push_pc(push_pc), .push_ready(push_ready),
        .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_inst(pop_inst), .pop_pc(pop_pc),
        .flush(flush), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs with the model's view of the queue.
    task automatic check_outputs(input string tag);
        logic [63:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 64'd0;
        check({tag, "_count"}, 64'(count), 64'(model_q.size()));
        check({tag, "_push_ready"}, 64'(push_ready), 64'(model_q.size() != DEPTH));
        check({tag, "_pop_valid"}, 64'(pop_valid), 64'(model_q.size() != 0));
        check({tag, "_pop_inst"}, 64'(pop_inst), 64'(head[31:0]));
        check({tag, "_pop_pc"}, 64'(pop_pc), 64'(head[63:32]));
    endtask

    // One clock cycle: drive at negedge, check, then apply the FIFO rules to the model at the edge.
    task automatic cycle(input string tag, input logic pv, input logic [31:0] pi,
                         input logic [31:0] pp, input logic pr, input logic fl);
        logic pf;
        logic of;
        @(negedge Clk);
        push_valid = pv;
        push_inst  = pi;
        push_pc    = pp;
        pop_ready  = pr;
        flush      = fl;
        #1;
        check_outputs(tag);
        pf = pv && (model_q.size() < DEPTH) && !fl;
        of = pr && (model_q.size() > 0) && !fl;
        @(posedge Clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (of) void'(model_q.pop_front());
            if (pf) model_q.push_back({pp, pi});
        end
    endtask

    task automatic idle_inputs();
        @(negedge Clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        logic [31:0] names [4];
        names[0] = 32'hA; names[1] = 32'hB; names[2] = 32'hC; names[3] = 32'hD;

        // Asynchronous reset between edges.
        #2 Rst = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd1);
        check("rst_pop_valid", 64'(pop_valid), 64'd0);
        check("rst_pop_inst", 64'(pop_inst), 64'd0);
        check("rst_pop_pc", 64'(pop_pc), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Fill A..D with decode stalled, then offer E which must be rejected.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, names[i], 32'(4 * (i + 1)), 1'b0, 1'b0);
        #1;
        check("fill_count", 64'(count), 64'd4);
        check("fill_push_ready", 64'(push_ready), 64'd0);
        cycle("full_push", 1'b1, 32'hE, 32'd20, 1'b0, 1'b0);
        #1;
        check("full_reject_count", 64'(count), 64'd4);
        check("full_head", 64'(pop_inst), 64'hA);

        // Drain in order, then the bubble.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge Clk);
            push_valid = 1'b0; pop_ready = 1'b1; flush = 1'b0;
            #1;
            check("drain_inst", 64'(pop_inst), 64'(names[i]));
            check("drain_pc", 64'(pop_pc), 64'(4 * (i + 1)));
            @(posedge Clk);
            void'(model_q.pop_front());
        end
        idle_inputs();
        #1;
        check("drain_empty_valid", 64'(pop_valid), 64'd0);
        check("drain_empty_nop", 64'(pop_inst), 64'd0);

        // Empty + push + pop_ready: entry stored, nothing popped.
        cycle("empty_pushpop", 1'b1, 32'h11, 32'h100, 1'b1, 1'b0);
        cycle("second", 1'b1, 32'h22, 32'h104, 1'b0, 1'b0);
        #1;
        check("two_count", 64'(count), 64'd2);
        // Simultaneous push and pop at count 2.
        cycle("simul", 1'b1, 32'h33, 32'h108, 1'b1, 1'b0);
        #1;
        check("simul_count", 64'(count), 64'd2);
        check("simul_head", 64'(pop_inst), 64'h22);
        cycle("to_three", 1'b1, 32'h44, 32'h10c, 1'b0, 1'b0);
        // Flush at count 3 with push and pop requested on the same edge.
        cycle("flush", 1'b1, 32'h55, 32'h110, 1'b1, 1'b1);
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_pop_valid", 64'(pop_valid), 64'd0);
        cycle("after_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Full + pop: push not accepted that cycle, ready returns afterwards.
        for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 32'h60 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        cycle("full_pushpop", 1'b1, 32'h6F, 32'h2F0, 1'b1, 1'b0);
        #1;
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_ready", 64'(push_ready), 64'd1);

        // Wrap: interleaved push/pop sequence.
        for (int i = 0; i < 10; i++) cycle("wrap", 1'b1, 32'h700 + 32'(i), 32'h300 + 32'(4 * i), i[0], 1'b0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            #1;
            check("rand_bound", 64'(count <= 3'd4), 64'd1);
        end

        // Asynchronous reset mid-operation drops everything immediately.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 32'h900 + 32'(i), 32'h40 + 32'(i), 1'b0, 1'b0);
        #2 Rst = 1'b1;
        #1;
        model_q.delete();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_pop_valid", 64'(pop_valid), 64'd0);
        check("mid_rst_pop_inst", 64'(pop_inst), 64'd0);
        check("mid_rst_push_ready", 64'(push_ready), 64'd1);
        @(negedge Clk);
        Rst = 1'b0;
        push_valid = 1'b0;
        cycle("post_rst", 1'b1, 32'hBEEF, 32'h4, 1'b0, 1'b0);
        cycle("post_rst2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("post_rst3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
